mil1553_encoder: RTL
====================

Name: mil1553_encoder

Overview:
- MIL-STD-1553B Manchester II word transmitter. It is the transmit-side counterpart of the PMOD 1553 receive path.
- Takes 16-bit words plus a sync type over a valid/ready stream from the UART-side logic.
- Emits a 20-bit-time bus word (3-bit sync, 16 data bits, odd parity) on the PMOD transmit pins: tx_p, tx_n, tx_en.
- Drives the differential transceiver directly. Contiguous words are sent without gaps.

Parameters:
- CLOCK_SPEED, 100000000: input clock frequency in Hz.
- BIT_RATE, 1000000: 1553 bit rate in bit/s. CLOCK_SPEED must be an integer multiple of 2*BIT_RATE.
- HALF_BIT_CNT, CLOCK_SPEED/(2*BIT_RATE): clock cycles per half-bit (50 at defaults). Derived; do not override.

Ports:
- clk, input, 1: system clock.
- resetn, input, 1: asynchronous active-low reset.
- s_data, input, 16: word to send, MSB transmitted first.
- s_cmd, input, 1: 1 = command/status sync, 0 = data sync.
- s_valid, input, 1: word valid.
- s_ready, output, 1: word accepted when s_valid & s_ready.
- tx_p, output, 1: positive transceiver drive.
- tx_n, output, 1: negative transceiver drive.
- tx_en, output, 1: transceiver enable (high only while a word is on the bus).
- busy, output, 1: high from accept until the final half-bit of the last word ends.

Behaviour:
- Reset is asynchronous, active-low, on resetn. All outputs reset to 0 except s_ready. s_ready resets to 0 and goes to 1 the first cycle after reset release.
- State machine:
  - IDLE -> SYNC -> DATA -> PARITY, then -> IDLE or -> SYNC.
  - All outputs are registered.
- Half-bit timing:
  - A counter runs 0..HALF_BIT_CNT-1.
  - A half-bit index runs 0..39 (6 sync, 32 data, 2 parity).
  - A strobe at counter = HALF_BIT_CNT-1 advances the index.
- IDLE:
  - s_ready = 1; tx_p = tx_n = tx_en = 0.
  - On accept, latch s_data and s_cmd, and compute odd parity (parity = ~^s_data).
  - Next cycle: enter SYNC, index = 0, tx_en = 1.
  - Latency is 1 clock from the accept edge to the first driven half-bit.
- SYNC:
  - Command sync: tx_p high for half-bits 0-2, low for 3-5.
  - Data sync: tx_p low for half-bits 0-2, high for 3-5.
- DATA: Manchester II per bit, MSB first. Logic 1 = high then low; logic 0 = low then high.
- PARITY: the parity bit, encoded the same way.
- tx_n = ~tx_p whenever tx_en = 1. tx_n = 0 when tx_en = 0.
- Contiguous words:
  - s_ready = 1 only in IDLE and on the final clock of half-bit 39.
  - An accept on that cycle goes straight to SYNC for the new word with zero dead time. tx_en stays high and busy stays high.
  - If there is no accept on that cycle, go to IDLE: tx_en, tx_p, tx_n drop to 0 and busy drops to 0 on the next cycle.
- Word length: exactly 40*HALF_BIT_CNT cycles (2000 at defaults).
- s_valid asserted while s_ready = 0: the word is held upstream; it is not dropped or latched.
- resetn asserted mid-word: the word is abandoned and outputs go to 0 immediately. Nothing is resumed after release.
- s_data and s_cmd changes outside an accept have no effect.

Optional Feature:
- Macro: MIL1553_PARITY_INJECT_EN.
- When defined:
  - Adds input port s_bad_parity (1 bit), sampled with s_data on accept.
  - When set, the transmitted parity bit is inverted (even parity), for receiver error testing.
- When undefined: the port is absent and parity is always odd.

Decomposition:
- Package mil1553_pkg holds:
  - sync type constants: SYNC_CMD = 1'b1, SYNC_DATA = 1'b0;
  - half-bit counts: SYNC_HALF_BITS = 6, DATA_HALF_BITS = 32, WORD_HALF_BITS = 40;
  - the state enum typedef;
  - a function computing odd parity.
- Sub-module mil1553_half_bit_tick: a free-run counter with sync clear, emitting a one-cycle strobe every HALF_BIT_CNT cycles. It is reusable by the decoder sampler.

Test Plan:
- Command word 16'h0000 with s_cmd = 1 -> tx_en high 2000 cycles. tx_p high 150 cycles, low 150, then 16 "0" bits (low 50 / high 50), then parity 1 (high 50 / low 50). tx_n is the complement throughout.
- Data word 16'hFFFF with s_cmd = 0 -> sync low 150 / high 150, 16 "1" bits, parity 1. Then idle with tx_p = tx_n = tx_en = 0.
- Word 16'h0001 followed by 16'h8000, s_valid held -> second accept on the final cycle of half-bit 39. The second sync starts the next cycle, tx_en never drops, and 4000 cycles total elapse. Both words carry parity 0.
- s_valid held during a word -> s_ready = 0 from cycle 1 through cycle 1998. The held word is accepted only on cycle 1999 of the word.
- resetn pulled low at cycle 700 of a word -> tx_en, tx_p, tx_n, busy = 0 asynchronously. After release, s_ready = 1 and nothing is transmitted until a new accept.
- MIL1553_PARITY_INJECT_EN, 16'h0000 with s_bad_parity = 1 -> parity half-bits low 50 / high 50, i.e. the parity bit is 0.

Source files
------------

// File: rtl/mil1553_pkg.sv
// rtl/mil1553_pkg.sv - shared constants, state type and parity helper for the 1553 encoder
package mil1553_pkg;

  localparam logic SYNC_CMD  = 1'b1;
  localparam logic SYNC_DATA = 1'b0;

  localparam int SYNC_HALF_BITS = 6;
  localparam int DATA_HALF_BITS = 32;
  localparam int WORD_HALF_BITS = 40;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_PARITY
  } state_e;

  function automatic logic odd_parity(input logic [15:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/mil1553_half_bit_tick.sv
// rtl/mil1553_half_bit_tick.sv - free-running half-bit counter with sync clear and strobes
// pre_tick_o fires one cycle ahead of tick_o so callers can register decisions for the last cycle.
module mil1553_half_bit_tick #(
  parameter int HALF_BIT_CNT = 50
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr_i,
  output logic tick_o,
  output logic pre_tick_o
);

  localparam int CW  = (HALF_BIT_CNT > 1) ? $clog2(HALF_BIT_CNT) : 1;
  localparam int PRE = (HALF_BIT_CNT > 1) ? HALF_BIT_CNT - 2 : 0;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o     = (cnt_q == CW'(HALF_BIT_CNT - 1));
  assign pre_tick_o = (cnt_q == CW'(PRE));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mil1553_encoder.sv
// rtl/mil1553_encoder.sv - MIL-STD-1553B Manchester II word transmitter driving the PMOD transceiver
// Optional MIL1553_PARITY_INJECT_EN adds s_bad_parity to force even parity for receiver testing.
module mil1553_encoder
  import mil1553_pkg::*;
#(
  parameter int CLOCK_SPEED  = 100000000,
  parameter int BIT_RATE     = 1000000,
  parameter int HALF_BIT_CNT = CLOCK_SPEED / (2 * BIT_RATE)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] s_data,
  input  logic        s_cmd,
  input  logic        s_valid,
`ifdef MIL1553_PARITY_INJECT_EN
  input  logic        s_bad_parity,
`endif
  output logic        s_ready,
  output logic        tx_p,
  output logic        tx_n,
  output logic        tx_en,
  output logic        busy
);

  localparam logic [5:0] LAST_HB = 6'(WORD_HALF_BITS - 1);

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [15:0] data_q, data_d;
  logic        cmd_q, cmd_d;
  logic        par_q, par_d;
  logic        s_ready_q, s_ready_d;
  logic        busy_q, busy_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_p_q, tx_p_d;
  logic        tx_n_q, tx_n_d;

  logic        tick, pre_tick, cnt_clr;
  logic        accept, new_par;

  mil1553_half_bit_tick #(
    .HALF_BIT_CNT(HALF_BIT_CNT)
  ) u_tick (
    .clk       (clk),
    .resetn    (resetn),
    .clr_i     (cnt_clr),
    .tick_o    (tick),
    .pre_tick_o(pre_tick)
  );

  function automatic state_e phase_of(input logic [5:0] h);
    if (h < 6'(SYNC_HALF_BITS))                       return ST_SYNC;
    else if (h < 6'(SYNC_HALF_BITS + DATA_HALF_BITS)) return ST_DATA;
    else                                              return ST_PARITY;
  endfunction

  // Line level for half-bit h: first half of a Manchester bit carries the bit value.
  function automatic logic half_bit_level(input logic [5:0] h, input logic cmd,
                                          input logic [15:0] data, input logic par);
    logic [4:0] d;
    logic       lvl;
    d = 5'(h - 6'(SYNC_HALF_BITS));
    case (phase_of(h))
      ST_SYNC: lvl = (cmd == SYNC_CMD) ? (h < 6'(SYNC_HALF_BITS / 2))
                                       : (h >= 6'(SYNC_HALF_BITS / 2));
      ST_DATA: lvl = data[4'd15 - d[4:1]] ^ d[0];
      default: lvl = par ^ h[0];
    endcase
    return lvl;
  endfunction

  assign accept = s_valid & s_ready_q;

`ifdef MIL1553_PARITY_INJECT_EN
  assign new_par = odd_parity(s_data) ^ s_bad_parity;
`else
  assign new_par = odd_parity(s_data);
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    cmd_d     = cmd_q;
    par_d     = par_q;
    s_ready_d = 1'b0;
    busy_d    = busy_q;
    tx_en_d   = tx_en_q;
    tx_p_d    = tx_p_q;
    cnt_clr   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        s_ready_d = 1'b1;
        busy_d    = 1'b0;
        tx_en_d   = 1'b0;
        tx_p_d    = 1'b0;
        if (accept) begin
          data_d    = s_data;
          cmd_d     = s_cmd;
          par_d     = new_par;
          state_d   = ST_SYNC;
          idx_d     = '0;
          cnt_clr   = 1'b1;
          busy_d    = 1'b1;
          tx_en_d   = 1'b1;
          s_ready_d = 1'b0;
          tx_p_d    = half_bit_level(6'd0, s_cmd, s_data, new_par);
        end
      end
      default: begin
        // Ready is raised for exactly the final clock of the last half-bit.
        if (pre_tick && idx_q == LAST_HB) s_ready_d = 1'b1;
        if (tick) begin
          if (idx_q == LAST_HB) begin
            if (accept) begin
              data_d  = s_data;
              cmd_d   = s_cmd;
              par_d   = new_par;
              state_d = ST_SYNC;
              idx_d   = '0;
              tx_p_d  = half_bit_level(6'd0, s_cmd, s_data, new_par);
            end else begin
              state_d   = ST_IDLE;
              idx_d     = '0;
              busy_d    = 1'b0;
              tx_en_d   = 1'b0;
              tx_p_d    = 1'b0;
              s_ready_d = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = phase_of(idx_d);
            tx_p_d  = half_bit_level(idx_d, cmd_q, data_q, par_q);
          end
        end
      end
    endcase

    tx_n_d = tx_en_d & ~tx_p_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      data_q    <= '0;
      cmd_q     <= SYNC_DATA;
      par_q     <= 1'b0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_p_q    <= 1'b0;
      tx_n_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      cmd_q     <= cmd_d;
      par_q     <= par_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
      tx_en_q   <= tx_en_d;
      tx_p_q    <= tx_p_d;
      tx_n_q    <= tx_n_d;
    end
  end

  assign s_ready = s_ready_q;
  assign busy    = busy_q;
  assign tx_en   = tx_en_q;
  assign tx_p    = tx_p_q;
  assign tx_n    = tx_n_q;

endmodule
